bpfcap_mem_responder: RTL and testbench

Avalon-MM memory responder that answers the bpfcap read master (m0, packet fetch) and write master (m1, result write-back). It stands in for HPS SDRAM in simulation and in fabric-only builds. Two independent slave ports (burst read, burst write) front a shared word-addressed dual-port RAM with fixed read latency and a test-controllable stall. Benches and fabric-only tops instantiate it directly against `bpfcap_top`.

---
 rtl/bpfcap_pkg.sv | 17 +
 rtl/bpfcap_dpram.sv | 25 ++
 rtl/bpfcap_mem_responder.sv | 206 ++++++++++++++++++++
 tb/tb_bpfcap_mem_responder.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpfcap_pkg.sv
// Shared types for the bpfcap memory responder.
// State encodings and the poison word returned for out-of-range reads.
package bpfcap_pkg;

    typedef enum logic {
        R_IDLE,
        R_BUSY
    } rd_state_t;

    typedef enum logic {
        W_IDLE,
        W_BURST
    } wr_state_t;

    localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

endpackage

// File: rtl/bpfcap_dpram.sv
// Simple dual-port RAM: one write port, one read port.
// Registered read; a same-address write in the same cycle returns old data.
module bpfcap_dpram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/bpfcap_mem_responder.sv
// Avalon-MM burst read/write responder over a shared dual-port RAM.
// Stands in for HPS SDRAM in simulation and fabric-only builds.
module bpfcap_mem_responder
    import bpfcap_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 1024,
    parameter int BURST_W  = 16,
    parameter int READ_LAT = 2,
    parameter int BASE     = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  rd_address,
    input  logic               rd_read,
    input  logic [BURST_W-1:0] rd_burstcount,
    output logic               rd_waitrequest,
    output logic [DATA_W-1:0]  rd_readdata,
    output logic               rd_readdatavalid,
    input  logic [ADDR_W-1:0]  wr_address,
    input  logic               wr_write,
    input  logic [DATA_W-1:0]  wr_writedata,
    input  logic [BURST_W-1:0] wr_burstcount,
    output logic               wr_waitrequest,
    input  logic               rd_stall,
    output logic               err
);

    localparam int SH    = $clog2(DATA_W / 8);
    localparam int AW    = $clog2(DEPTH);
    localparam int IDX_W = AW + 1;

    localparam logic [ADDR_W-1:0]  BASE_A  = ADDR_W'(BASE);
    localparam logic [ADDR_W-1:0]  DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [IDX_W-1:0]   DEPTH_I = IDX_W'(DEPTH);
    localparam logic [IDX_W-1:0]   ONE_I   = IDX_W'(1);
    localparam logic [BURST_W-1:0] ONE_B   = BURST_W'(1);

    rd_state_t          rd_state;
    wr_state_t          wr_state;
    logic [IDX_W-1:0]   rd_idx, wr_idx;
    logic               rd_oor, wr_oor;
    logic [BURST_W-1:0] rd_rem, wr_rem;

    logic [ADDR_W-1:0]  rd_word, wr_word;
    logic               rd_start_oor, wr_start_oor;
    logic               rd_accept, rd_issue, rd_beat_oor;
    logic               wr_accept, wr_first, wr_beat_oor;
    logic               ram_we;
    logic [AW-1:0]      ram_waddr, ram_raddr;
    logic [DATA_W-1:0]  ram_q, pipe_d;
    logic               pipe_busy, err_set;

    logic pv [READ_LAT];
    logic po [READ_LAT];

    // Start word decode; oor flags go sticky so index wrap is never aliased
    assign rd_word      = (rd_address - BASE_A) >> SH;
    assign wr_word      = (wr_address - BASE_A) >> SH;
    assign rd_start_oor = (rd_address < BASE_A) || (rd_word >= DEPTH_A);
    assign wr_start_oor = (wr_address < BASE_A) || (wr_word >= DEPTH_A);

    assign rd_waitrequest = reset | rd_stall | (rd_state != R_IDLE);
    assign rd_accept      = rd_read & ~rd_waitrequest;
    assign rd_issue       = rd_accept
                          | ((rd_state == R_BUSY) && (rd_rem != '0));
    assign rd_beat_oor    = rd_accept ? rd_start_oor
                                      : (rd_oor | (rd_idx >= DEPTH_I));
    assign ram_raddr      = rd_accept ? rd_word[AW-1:0] : rd_idx[AW-1:0];

    assign wr_waitrequest = reset;
    assign wr_accept      = wr_write & ~reset;
    assign wr_first       = wr_accept && (wr_state == W_IDLE);
    assign wr_beat_oor    = wr_first ? wr_start_oor
                                     : (wr_oor | (wr_idx >= DEPTH_I));
    assign ram_we         = wr_accept & ~wr_beat_oor;
    assign ram_waddr      = wr_first ? wr_word[AW-1:0] : wr_idx[AW-1:0];

    assign err_set = (rd_accept && (rd_burstcount == '0))
                   | (rd_issue && rd_beat_oor)
                   | (wr_first && (wr_burstcount == '0))
                   | (wr_accept && wr_beat_oor);

    bpfcap_dpram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk    (clk),
        .we     (ram_we),
        .waddr  (ram_waddr),
        .wdata  (wr_writedata),
        .raddr  (ram_raddr),
        .rdata  (ram_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state <= R_IDLE;
            rd_idx   <= '0;
            rd_oor   <= 1'b0;
            rd_rem   <= '0;
        end else begin
            case (rd_state)
                R_IDLE: if (rd_accept) begin
                    rd_state <= R_BUSY;
                    rd_idx   <= rd_word[IDX_W-1:0] + ONE_I;
                    rd_oor   <= rd_start_oor;
                    rd_rem   <= (rd_burstcount == '0) ? '0
                                                      : rd_burstcount - ONE_B;
                end
                R_BUSY: if (rd_rem != '0) begin
                    rd_idx <= rd_idx + ONE_I;
                    rd_oor <= rd_beat_oor;
                    rd_rem <= rd_rem - ONE_B;
                end else if (!pipe_busy) begin
                    rd_state <= R_IDLE;
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state <= W_IDLE;
            wr_idx   <= '0;
            wr_oor   <= 1'b0;
            wr_rem   <= '0;
        end else begin
            case (wr_state)
                W_IDLE: if (wr_write) begin
                    wr_idx <= wr_word[IDX_W-1:0] + ONE_I;
                    wr_oor <= wr_start_oor;
                    if (wr_burstcount > ONE_B) begin
                        wr_state <= W_BURST;
                        wr_rem   <= wr_burstcount - ONE_B;
                    end
                end
                W_BURST: if (wr_write) begin
                    wr_idx <= wr_idx + ONE_I;
                    wr_oor <= wr_beat_oor;
                    wr_rem <= wr_rem - ONE_B;
                    if (wr_rem == ONE_B) begin
                        wr_state <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < READ_LAT; k++) begin
                pv[k] <= 1'b0;
                po[k] <= 1'b0;
            end
        end else begin
            pv[0] <= rd_issue;
            po[0] <= rd_beat_oor;
            for (int k = 1; k < READ_LAT; k++) begin
                pv[k] <= pv[k-1];
                po[k] <= po[k-1];
            end
        end
    end

    // Stage 0 is the RAM output register; data stages follow it
    generate
        if (READ_LAT > 1) begin : g_pipe
            logic [DATA_W-1:0] pd [READ_LAT-1];
            always_ff @(posedge clk) begin
                pd[0] <= ram_q;
                for (int k = 1; k < READ_LAT - 1; k++) begin
                    pd[k] <= pd[k-1];
                end
            end
            assign pipe_d = pd[READ_LAT-2];
        end else begin : g_direct
            assign pipe_d = ram_q;
        end
    endgenerate

    always_comb begin
        pipe_busy = 1'b0;
        for (int k = 0; k < READ_LAT - 1; k++) begin
            pipe_busy = pipe_busy | pv[k];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end
    end

    assign rd_readdatavalid = pv[READ_LAT-1];
    assign rd_readdata      = !pv[READ_LAT-1] ? '0
                            : po[READ_LAT-1]  ? DATA_W'(ERR_WORD)
                                              : pipe_d;

endmodule

// File: tb/tb_bpfcap_mem_responder.sv
// Scoreboard bench for bpfcap_mem_responder.
// Word-array reference model; a negedge monitor checks every read beat.
module tb_bpfcap_mem_responder;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int DEPTH    = 1024;
    localparam int BURST_W  = 16;
    localparam int READ_LAT = 2;
    localparam int BASE     = 0;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [ADDR_W-1:0]  rd_address = '0;
    logic               rd_read = 1'b0;
    logic [BURST_W-1:0] rd_burstcount = '0;
    logic               rd_waitrequest;
    logic [DATA_W-1:0]  rd_readdata;
    logic               rd_readdatavalid;
    logic [ADDR_W-1:0]  wr_address = '0;
    logic               wr_write = 1'b0;
    logic [DATA_W-1:0]  wr_writedata = '0;
    logic [BURST_W-1:0] wr_burstcount = '0;
    logic               wr_waitrequest;
    logic               rd_stall = 1'b0;
    logic               err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] model [DEPTH];
    logic        err_exp = 1'b0;

    bpfcap_mem_responder #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .BURST_W  (BURST_W),
        .READ_LAT (READ_LAT),
        .BASE     (BASE)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .rd_address       (rd_address),
        .rd_read          (rd_read),
        .rd_burstcount    (rd_burstcount),
        .rd_waitrequest   (rd_waitrequest),
        .rd_readdata      (rd_readdata),
        .rd_readdatavalid (rd_readdatavalid),
        .wr_address       (wr_address),
        .wr_write         (wr_write),
        .wr_writedata     (wr_writedata),
        .wr_burstcount    (wr_burstcount),
        .wr_waitrequest   (wr_waitrequest),
        .rd_stall         (rd_stall),
        .err              (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [31:0] exp_word(input int idx);
        if (idx < 0 || idx >= DEPTH) return 32'hDEAD_BEEF;
        return model[idx];
    endfunction

    task automatic check1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%b want=%b cyc=%0d", name, act, req, cyc);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act,
                           input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%h want=%h cyc=%0d", name, act, req, cyc);
        end
    endtask

    // Monitor: every delivered beat must match the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rd_readdatavalid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_beat_unexpected cyc=%0d data=%h", cyc, rd_readdata);
            end else begin
                e = exp_q.pop_front();
                if (rd_readdata !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL rd_beat got cyc=%0d data=%h want cyc=%0d data=%h",
                             cyc, rd_readdata, e.cyc, e.data);
                end
            end
        end
    end

    task automatic do_read(input int word, input int b, output int n);
        int  bb;
        bit  acc;
        acc = 0;
        n = -1;
        rd_address = 32'(BASE + word * 4);
        rd_burstcount = 16'(b);
        rd_read = 1'b1;
        for (int t = 0; t < 300 && !acc; t++) begin
            @(negedge clk);
            if (!rd_waitrequest) begin
                acc = 1;
                n = cyc;
                bb = (b == 0) ? 1 : b;
                if (b == 0) err_exp = 1'b1;
                for (int k = 0; k < bb; k++) begin
                    if (word + k >= DEPTH) err_exp = 1'b1;
                    exp_q.push_back('{exp_word(word + k), cyc + READ_LAT + k});
                end
            end
            @(posedge clk);
            #1;
        end
        rd_read = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL rd_accept timeout word=%0d", word);
        end
    endtask

    task automatic do_write(input int word, input int bc, input bit fixed,
                            input logic [31:0] d0, input int gap_at,
                            input int gap_len);
        int          nb;
        logic [31:0] d;
        nb = (bc == 0) ? 1 : bc;
        if (bc == 0) err_exp = 1'b1;
        for (int k = 0; k < nb; k++) begin
            if (k == gap_at && k > 0) begin
                wr_write = 1'b0;
                wr_writedata = $urandom;
                repeat (gap_len) begin
                    @(posedge clk);
                    #1;
                end
            end
            d = fixed ? d0 + 32'(k) : $urandom;
            wr_write = 1'b1;
            wr_writedata = d;
            if (k == 0) begin
                wr_address = 32'(BASE + word * 4);
                wr_burstcount = 16'(bc);
            end else begin
                wr_address = $urandom;
                wr_burstcount = 16'($urandom);
            end
            @(negedge clk);
            check1("wr_waitrequest", wr_waitrequest, 1'b0);
            @(posedge clk);
            if (word + k < DEPTH) model[word + k] = d;
            else err_exp = 1'b1;
            #1;
        end
        wr_write = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || rd_waitrequest) && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        checks++;
        if (t >= 500) begin
            errors++;
            $display("FAIL drain timeout pending=%0d", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n1, n2, c0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check1("rst_rd_waitreq", rd_waitrequest, 1'b1);
        check1("rst_wr_waitreq", wr_waitrequest, 1'b1);
        check1("rst_valid", rd_readdatavalid, 1'b0);
        check32("rst_readdata", rd_readdata, 32'h0);
        check1("rst_err", err, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check1("post_rst_rd_waitreq", rd_waitrequest, 1'b0);
        check1("post_rst_wr_waitreq", wr_waitrequest, 1'b0);
        @(posedge clk);
        #1;

        do_write(0, DEPTH, 1'b0, 32'h0, 0, 0);
        check1("fill_err", err, err_exp);

        do_write(8, 4, 1'b1, 32'd10, 0, 0);
        do_read(8, 4, n);
        drain();
        check1("burst4_err", err, 1'b0);

        do_write(40, 4, 1'b0, 32'h0, 2, 2);
        do_read(40, 5, n);
        drain();
        check1("gap_err", err, 1'b0);

        rd_stall = 1'b1;
        rd_address = 32'(BASE + 8 * 4);
        rd_burstcount = 16'd2;
        rd_read = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check1("stall_waitreq", rd_waitrequest, 1'b1);
            @(posedge clk);
            #1;
        end
        rd_stall = 1'b0;
        c0 = cyc;
        do_read(8, 2, n);
        check32("stall_accept_cyc", 32'(n), 32'(c0));
        drain();

        do_write(8, 1, 1'b1, 32'hAA, 0, 0);
        drain();
        wr_write = 1'b1;
        wr_address = 32'(BASE + 8 * 4);
        wr_burstcount = 16'd1;
        wr_writedata = 32'h55;
        rd_read = 1'b1;
        rd_address = 32'(BASE + 8 * 4);
        rd_burstcount = 16'd1;
        @(negedge clk);
        check1("rf_accept", rd_waitrequest, 1'b0);
        exp_q.push_back('{exp_word(8), cyc + READ_LAT});
        @(posedge clk);
        model[8] = 32'h55;
        #1;
        wr_write = 1'b0;
        rd_read = 1'b0;
        drain();
        do_read(8, 1, n);
        drain();

        do_read(100, 3, n1);
        do_read(200, 2, n2);
        check32("b2b_accept_cyc", 32'(n2), 32'(n1 + READ_LAT + 3));
        drain();

        do_read(DEPTH - 2, 3, n);
        drain();
        check1("oor_err", err, 1'b1);

        do_read(100, 8, n);
        while (cyc < n + READ_LAT + 1) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        @(negedge clk);
        check1("rst_mid_valid", rd_readdatavalid, 1'b0);
        check1("rst_mid_waitreq", rd_waitrequest, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        err_exp = 1'b0;
        @(negedge clk);
        check1("rst_mid_rd_waitreq", rd_waitrequest, 1'b0);
        check1("rst_mid_wr_waitreq", wr_waitrequest, 1'b0);
        check1("rst_mid_err", err, 1'b0);
        @(posedge clk);
        #1;

        do_read(5, 0, n);
        drain();
        check1("bc0_err", err, 1'b1);

        for (int i = 0; i < 40; i++) begin
            int w, b, ga, gl;
            w = int'($urandom_range(DEPTH + 2, 0));
            b = int'($urandom_range(8, 1));
            if ($urandom_range(1, 0) == 1) begin
                ga = int'($urandom_range(b - 1, 0));
                gl = int'($urandom_range(2, 0));
                do_write(w, b, 1'b0, 32'h0, ga, gl);
            end else begin
                do_read(w, b, n);
            end
            drain();
            check1("rand_err", err, err_exp);
        end

        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
